memory_responder: RTL and testbench

Word-addressed memory that answers the Read/Write strobes issued by the control sequencer and returns read data on the `Mdatain` bus into the datapath's MDR input mux. Requests are latched in full, held for a programmable number of wait states, then completed with a one-cycle `mem_done` pulse. The block is the memory-side end of the MAR/MDR interface and removes the need for testbenches to hand-drive `Mdatain`.

---
 rtl/memory_responder.sv | 137 +++++++++++++
 tb/tb_memory_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// Word-addressed memory answering the sequencer's Read/Write strobes.
// Each request is latched, delayed by WAIT_STATES cycles, then completed with a mem_done pulse.
module memory_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  Clock,
    input  logic                  clear,
    input  logic                  Read,
    input  logic                  Write,
    input  logic [31:0]           MAR_addr,
    input  logic [DATA_WIDTH-1:0] MDR_data,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_done,
    output logic                  mem_busy,
    output logic                  addr_err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic [2:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  mem_done_q, mem_done_d;
    logic                  mem_busy_q, mem_busy_d;
    logic                  addr_err_q, addr_err_d;
    logic [DATA_WIDTH-1:0] mdatain_q, mdatain_d;

    // Request latches and read capture carry data only, so they are left out of reset
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic bad_req;
    assign bad_req = (Read && Write) || (|MAR_addr[31:ADDR_WIDTH]);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (Read || Write) begin
                    rd_d    = Read;
                    wr_d    = Write;
                    addr_d  = MAR_addr[ADDR_WIDTH-1:0];
                    wdata_d = MDR_data;
                    cnt_d   = 4'(WAIT_STATES);
                    err_d   = bad_req;
                    if (bad_req)
                        state_d = S_DONE;
                    else if (WAIT_STATES > 0)
                        state_d = S_WAIT;
                    else
                        state_d = S_ACCESS;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1)
                    state_d = S_ACCESS;
            end
            S_ACCESS: begin
                rdata_d = mem[addr_q];
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = (Read || Write) ? S_RELEASE : S_IDLE;
            end
            S_RELEASE: begin
                if (!Read && !Write)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered one cycle behind the state they report
    always_comb begin
        mem_done_d = (state_q == S_DONE);
        addr_err_d = (state_q == S_DONE) && err_q;
        mem_busy_d = (state_q == S_WAIT) || (state_q == S_ACCESS) || (state_q == S_DONE);
        mdatain_d  = mdatain_q;
        if (state_q == S_DONE && rd_q)
            mdatain_d = err_q ? '0 : rdata_q;
    end

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            err_q      <= 1'b0;
            mem_done_q <= 1'b0;
            mem_busy_q <= 1'b0;
            addr_err_q <= 1'b0;
            mdatain_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            mem_done_q <= mem_done_d;
            mem_busy_q <= mem_busy_d;
            addr_err_q <= addr_err_d;
            mdatain_q  <= mdatain_d;
        end
    end

    always_ff @(posedge Clock) begin
        rd_q    <= rd_d;
        wr_q    <= wr_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        if (state_q == S_ACCESS && wr_q && !err_q)
            mem[addr_q] <= wdata_q;
    end

    assign Mdatain  = mdatain_q;
    assign mem_done = mem_done_q;
    assign mem_busy = mem_busy_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: one instance with two wait states, one with none.
// Expected completions are queued at request time and checked when mem_done fires.
module tb_memory_responder;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic        rd_a = 1'b0, wr_a = 1'b0, rd_b = 1'b0, wr_b = 1'b0;
    logic [31:0] mar_a = '0, mdr_a = '0, mar_b = '0, mdr_b = '0;
    logic [31:0] dout_a, dout_b;
    logic        done_a, busy_a, err_a, done_b, busy_b, err_b;

    typedef struct packed {
        logic [31:0] data;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;

    always #5 Clock = ~Clock;

    memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) dut (
        .Clock(Clock), .clear(clear), .Read(rd_a), .Write(wr_a),
        .MAR_addr(mar_a), .MDR_data(mdr_a), .Mdatain(dout_a),
        .mem_done(done_a), .mem_busy(busy_a), .addr_err(err_a)
    );

    memory_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .Clock(Clock), .clear(clear), .Read(rd_b), .Write(wr_b),
        .MAR_addr(mar_b), .MDR_data(mdr_b), .Mdatain(dout_b),
        .mem_done(done_b), .mem_busy(busy_b), .addr_err(err_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every completion pops one expectation
    always @(negedge Clock) begin
        if (done_a === 1'b1 || done_b === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("sb_addr_err", {31'd0, (done_a ? err_a : err_b)}, {31'd0, e.err});
                if (e.chk)
                    check("sb_mdatain", done_a ? dout_a : dout_b, e.data);
            end
        end
    end

    task automatic req(input bit sel, input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input int lat, input logic [31:0] xd,
                       input logic xerr, input logic chk);
        int n;
        bit got;
        @(negedge Clock);
        if (sel) begin rd_b = r; wr_b = w; mar_b = a; mdr_b = d; end
        else     begin rd_a = r; wr_a = w; mar_a = a; mdr_a = d; end
        sb.push_back('{data: xd, err: xerr, chk: chk});
        @(posedge Clock);
        n = 0;
        got = 0;
        while (n < 30 && !got) begin
            @(negedge Clock);
            n++;
            if ((sel ? done_b : done_a) === 1'b1) got = 1;
        end
        if (!got) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", n, lat + 1);
            check("busy_at_done", {31'd0, (sel ? busy_b : busy_a)}, 32'd1);
        end
        rd_a = 1'b0; wr_a = 1'b0; rd_b = 1'b0; wr_b = 1'b0;
        @(negedge Clock);
        check("done_pulse_width", {31'd0, (sel ? done_b : done_a)}, 32'd0);
        check("busy_after_done", {31'd0, (sel ? busy_b : busy_a)}, 32'd0);
        check("err_after_done", {31'd0, (sel ? err_b : err_a)}, 32'd0);
    endtask

    initial begin
        int base;
        int k;
        // reset values
        repeat (2) @(negedge Clock);
        check("rst_mdatain", dout_a, 32'd0);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_err", {31'd0, err_a}, 32'd0);
        clear = 1'b0;

        // write then read, two wait states
        req(0, 1'b0, 1'b1, 32'h010, 32'h28918000, 4, 32'h0, 1'b0, 1'b1);
        req(0, 1'b1, 1'b0, 32'h010, 32'h0, 4, 32'h28918000, 1'b0, 1'b1);

        // out-of-range read
        req(0, 1'b1, 1'b0, 32'h200, 32'h0, 1, 32'h0, 1'b1, 1'b1);

        // both strobes: rejected, memory untouched
        req(0, 1'b1, 1'b1, 32'h010, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 1'b0);
        req(0, 1'b1, 1'b0, 32'h010, 32'h0, 4, 32'h28918000, 1'b0, 1'b1);

        // seed 0x020, then abort a write to it with clear during WAIT
        req(0, 1'b0, 1'b1, 32'h020, 32'h14, 4, 32'h28918000, 1'b0, 1'b1);
        @(negedge Clock);
        wr_a = 1'b1; mar_a = 32'h020; mdr_a = 32'h12;
        @(posedge Clock);
        repeat (2) @(negedge Clock);
        check("busy_before_clear", {31'd0, busy_a}, 32'd1);
        clear = 1'b1;
        #1;
        check("clr_busy", {31'd0, busy_a}, 32'd0);
        check("clr_mdatain", dout_a, 32'd0);
        check("clr_done", {31'd0, done_a}, 32'd0);
        wr_a = 1'b0;
        @(negedge Clock);
        clear = 1'b0;
        base = done_cnt;
        repeat (8) @(negedge Clock);
        check("no_done_after_clear", done_cnt - base, 32'd0);
        req(0, 1'b1, 1'b0, 32'h020, 32'h0, 4, 32'h14, 1'b0, 1'b1);

        // held strobe: one pulse per rising request
        base = done_cnt;
        @(negedge Clock);
        sb.push_back('{data: 32'h14, err: 1'b0, chk: 1'b1});
        rd_a = 1'b1; mar_a = 32'h020;
        repeat (10) @(negedge Clock);
        check("held_one_pulse", done_cnt - base, 32'd1);
        rd_a = 1'b0;
        @(negedge Clock);
        sb.push_back('{data: 32'h14, err: 1'b0, chk: 1'b1});
        rd_a = 1'b1;
        k = 0;
        while (k < 20 && (done_cnt - base) < 2) begin
            @(negedge Clock);
            k++;
        end
        repeat (6) @(negedge Clock);
        check("held_second_pulse", done_cnt - base, 32'd2);
        rd_a = 1'b0;
        repeat (2) @(negedge Clock);

        // zero wait states
        req(1, 1'b0, 1'b1, 32'h001, 32'h18, 2, 32'h0, 1'b0, 1'b1);
        req(1, 1'b1, 1'b0, 32'h001, 32'h0, 2, 32'h18, 1'b0, 1'b1);

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
